// File: rtl/cumsum_reverse_row_sequencer_if.sv
// Stream bundle for the reverse-cumsum row sequencer: row input, result output, status.
// A beat transfers on any rising clk edge where valid && ready; the sender holds valid, data and last stable until then.
interface cumsum_reverse_row_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
);
    logic [ADDR_W:0]   cfg_len;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              busy;

    modport master (
        output cfg_len, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy
    );

    modport slave (
        input  cfg_len, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, busy
    );
endinterface

// File: rtl/cumsum_reverse_row_sequencer.sv
// Reverse cumulative sum over one buffered row: load forward, scan backward in place,
// then drain out[i] = x[i] + ... + x[len-1] in forward order.
module cumsum_reverse_row_sequencer #(
    parameter int DATA_W  = 32,
    parameter int MAX_LEN = 64,
    parameter int ADDR_W  = 6
) (
    input  logic clk,
    input  logic rst,
    cumsum_reverse_row_sequencer_if.slave bus
);
    localparam int LW = ADDR_W + 1;
    localparam logic [ADDR_W:0] LEN_MAX = LW'(MAX_LEN);
    localparam logic [ADDR_W:0] LEN_ONE = LW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SCAN  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W:0]   len;
    logic [ADDR_W-1:0] wr_idx;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] rd_idx;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] mem [MAX_LEN];

    logic              in_ready_r;
    logic              out_valid_r;
    logic [DATA_W-1:0] out_data_r;
    logic              out_last_r;
    logic              busy_r;

    logic [ADDR_W:0]   eff_len;
    logic [ADDR_W:0]   len_m1;
    logic [ADDR_W-1:0] rd_nxt;
    logic [DATA_W-1:0] scan_sum;
    logic              accept;
    logic              out_hs;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_last  = out_last_r;
    assign bus.busy      = busy_r;

    always_comb begin
        eff_len  = bus.cfg_len;
        if (bus.cfg_len == '0 || bus.cfg_len > LEN_MAX) begin
            eff_len = LEN_MAX;
        end
        len_m1   = len - LEN_ONE;
        rd_nxt   = rd_idx + ADDR_W'(1);
        scan_sum = acc + mem[idx];
        accept   = bus.in_valid && in_ready_r;
        out_hs   = out_valid_r && bus.out_ready;
    end

    // One buffer write port shared by loading (forward) and scanning (backward, in place).
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = bus.in_data;
        case (state)
            IDLE: begin
                wr_en   = accept;
                wr_addr = '0;
            end
            LOAD: begin
                wr_en   = accept;
                wr_addr = wr_idx;
            end
            SCAN: begin
                wr_en   = 1'b1;
                wr_addr = idx;
                wr_data = scan_sum;
            end
            default: wr_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            len         <= '0;
            wr_idx      <= '0;
            idx         <= '0;
            rd_idx      <= '0;
            acc         <= '0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready_r <= 1'b1;
                    if (accept) begin
                        len    <= eff_len;
                        wr_idx <= ADDR_W'(1);
                        busy_r <= 1'b1;
                        if (eff_len == LEN_ONE) begin
                            state      <= SCAN;
                            in_ready_r <= 1'b0;
                            idx        <= '0;
                            acc        <= '0;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        wr_idx <= wr_idx + ADDR_W'(1);
                        if ({1'b0, wr_idx} == len_m1) begin
                            state      <= SCAN;
                            in_ready_r <= 1'b0;
                            idx        <= len_m1[ADDR_W-1:0];
                            acc        <= '0;
                        end
                    end
                end
                SCAN: begin
                    acc <= scan_sum;
                    if (idx == '0) begin
                        // out[0] is the final sum itself, so present it without a buffer read.
                        state       <= DRAIN;
                        rd_idx      <= '0;
                        out_valid_r <= 1'b1;
                        out_data_r  <= scan_sum;
                        out_last_r  <= (len == LEN_ONE);
                    end else begin
                        idx <= idx - ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    if (out_hs) begin
                        if (out_last_r) begin
                            state       <= IDLE;
                            out_valid_r <= 1'b0;
                            out_last_r  <= 1'b0;
                            busy_r      <= 1'b0;
                            in_ready_r  <= 1'b1;
                        end else begin
                            rd_idx     <= rd_nxt;
                            out_data_r <= mem[rd_nxt];
                            out_last_r <= ({1'b0, rd_nxt} == len_m1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cumsum_reverse_row_sequencer.sv
// Directed bench for the reverse-cumsum row sequencer: values, latency, stalls, wrap,
// length boundaries, mid-row reset and back-to-back rows.
module tb_cumsum_reverse_row_sequencer;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 6;
    localparam int MAX_LEN = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    logic [DATA_W-1:0] row [MAX_LEN];
    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] got_q [$];
    logic              got_last_q [$];
    int first_acc, last_acc, first_valid, last_hs, stray, unstable;

    cumsum_reverse_row_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    cumsum_reverse_row_sequencer #(
        .DATA_W(DATA_W), .MAX_LEN(MAX_LEN), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Beats after the first carry a junk cfg_len so a re-sampling DUT would be caught.
    task automatic load_row(input int n, input logic [ADDR_W:0] cfg, input bit hold);
        int g;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = row[i];
            bus.cfg_len  = (i == 0) ? cfg : 7'd1;
            g = 0;
            while (!bus.in_ready && g < 500) begin
                @(negedge clk);
                g++;
            end
            if (!bus.in_ready) begin
                errors++;
                checks++;
                $display("FAIL load_timeout: beat %0d not accepted, in_ready=%0b want 1", i, bus.in_ready);
                bus.in_valid = 1'b0;
                return;
            end
            if (i == 0) first_acc = cyc;
            last_acc = cyc;
        end
        @(negedge clk);
        stray = (bus.in_valid && bus.in_ready) ? 1 : 0;
        if (!hold) bus.in_valid = 1'b0;
    endtask

    task automatic drain_row(input int n, input bit toggle);
        int k, g, t;
        logic stalled;
        logic [DATA_W-1:0] pd;
        logic pl;
        k = 0; g = 0; t = 0; stalled = 1'b0; pd = '0; pl = 1'b0;
        got_q.delete();
        got_last_q.delete();
        first_valid = -1;
        unstable = 0;
        while (k < n && g < 2000) begin
            @(negedge clk);
            g++;
            if (bus.in_valid && bus.in_ready) stray++;
            if (stalled && (!bus.out_valid || bus.out_data !== pd || bus.out_last !== pl)) unstable++;
            if (bus.out_valid && first_valid < 0) first_valid = cyc;
            bus.out_ready = toggle ? (t % 3 == 0) : 1'b1;
            if (bus.out_valid) t++;
            stalled = bus.out_valid && !bus.out_ready;
            pd = bus.out_data;
            pl = bus.out_last;
            if (bus.out_valid && bus.out_ready) begin
                got_q.push_back(bus.out_data);
                got_last_q.push_back(bus.out_last);
                k++;
                last_hs = cyc;
            end
        end
        if (k < n) begin
            errors++;
            checks++;
            $display("FAIL drain_timeout: got %0d results, want %0d", k, n);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %0b want 0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %0b want 0", bus.out_valid); end
        checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last: got %0b want 0", bus.out_last); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b want 0", bus.busy); end
        checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL rst_out_data: got %0h want 0", bus.out_data); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready: got %0b want 1", bus.in_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %0b want 0", bus.busy); end
    endtask

    task automatic test_basic(input bit toggle);
        logic [DATA_W-1:0] e;
        row[0] = 32'd1; row[1] = 32'd2; row[2] = 32'd3; row[3] = 32'd4;
        exp_q = '{32'd10, 32'd9, 32'd7, 32'd4};
        load_row(4, 7'd4, 1'b0);
        drain_row(4, toggle);
        checks++;
        if (first_valid - last_acc !== 5) begin
            errors++; $display("FAIL basic_latency toggle=%0b: got %0d want 5", toggle, first_valid - last_acc);
        end
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q[i] !== e) begin errors++; $display("FAIL basic_data[%0d] toggle=%0b: got %0h want %0h", i, toggle, got_q[i], e); end
            checks++;
            if (got_last_q[i] !== (i == 3)) begin errors++; $display("FAIL basic_last[%0d]: got %0b want %0b", i, got_last_q[i], (i == 3)); end
        end
        checks++; if (unstable !== 0) begin errors++; $display("FAIL basic_stable toggle=%0b: got %0d unstable cycles want 0", toggle, unstable); end
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL basic_idle: busy=%0b out_valid=%0b in_ready=%0b want 0 0 1", bus.busy, bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_wrap();
        row[0] = 32'hFFFFFFFF; row[1] = 32'h2;
        exp_q = '{32'h1, 32'h2};
        load_row(2, 7'd2, 1'b0);
        drain_row(2, 1'b0);
        for (int i = 0; i < 2; i++) begin
            logic [DATA_W-1:0] e;
            e = exp_q.pop_front();
            checks++;
            if (got_q[i] !== e) begin errors++; $display("FAIL wrap_data[%0d]: got %0h want %0h", i, got_q[i], e); end
        end
        checks++; if (got_last_q[1] !== 1'b1) begin errors++; $display("FAIL wrap_last: got %0b want 1", got_last_q[1]); end
    endtask

    task automatic test_len_one();
        row[0] = 32'd7;
        load_row(1, 7'd1, 1'b0);
        drain_row(1, 1'b0);
        checks++; if (first_valid - last_acc !== 2) begin errors++; $display("FAIL len1_latency: got %0d want 2", first_valid - last_acc); end
        checks++; if (got_q[0] !== 32'd7) begin errors++; $display("FAIL len1_data: got %0h want 7", got_q[0]); end
        checks++; if (got_last_q[0] !== 1'b1) begin errors++; $display("FAIL len1_last: got %0b want 1", got_last_q[0]); end
    endtask

    // cfg_len = 0 means a full 64-element row; in_valid stays high afterwards to prove no 65th beat.
    task automatic test_len_zero();
        logic [DATA_W-1:0] e;
        int bad;
        bad = 0;
        for (int i = 0; i < MAX_LEN; i++) row[i] = DATA_W'(i + 1);
        for (int i = 0; i < MAX_LEN; i++) exp_q.push_back(DATA_W'(2080 - (i * (i + 1)) / 2));
        load_row(MAX_LEN, 7'd0, 1'b1);
        drain_row(MAX_LEN, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++; if (stray !== 0) begin errors++; $display("FAIL len0_extra_beats: got %0d want 0", stray); end
        checks++; if (first_valid - last_acc !== 65) begin errors++; $display("FAIL len0_latency: got %0d want 65", first_valid - last_acc); end
        for (int i = 0; i < MAX_LEN; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q[i] !== e || got_last_q[i] !== (i == MAX_LEN - 1)) begin
                errors++; $display("FAIL len0_data[%0d]: got %0h/%0b want %0h/%0b", i, got_q[i], got_last_q[i], e, (i == MAX_LEN - 1));
            end
        end
        checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL len0_idle: busy=%0b out_valid=%0b want 0 0", bus.busy, bus.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        row[0] = 32'd100; row[1] = 32'd200; row[2] = 32'd300; row[3] = 32'd400;
        load_row(4, 7'd4, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.busy !== 1'b0 || bus.out_data !== 32'h0) begin
            errors++; $display("FAIL midrst_outputs: in_ready=%0b out_valid=%0b out_last=%0b busy=%0b out_data=%0h want all 0",
                bus.in_ready, bus.out_valid, bus.out_last, bus.busy, bus.out_data);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL midrst_after: out_valid=%0b busy=%0b want 0 0", bus.out_valid, bus.busy);
        end
        row[0] = 32'd5; row[1] = 32'd5; row[2] = 32'd5;
        exp_q = '{32'd15, 32'd10, 32'd5};
        load_row(3, 7'd3, 1'b0);
        drain_row(3, 1'b0);
        checks++; if (first_valid - last_acc !== 4) begin errors++; $display("FAIL midrst_latency: got %0d want 4", first_valid - last_acc); end
        for (int i = 0; i < 3; i++) begin
            logic [DATA_W-1:0] e;
            e = exp_q.pop_front();
            checks++;
            if (got_q[i] !== e) begin errors++; $display("FAIL midrst_data[%0d]: got %0h want %0h", i, got_q[i], e); end
        end
    endtask

    task automatic test_back_to_back();
        row[0] = 32'd1; row[1] = 32'd2; row[2] = 32'd3;
        load_row(3, 7'd3, 1'b1);
        drain_row(3, 1'b0);
        checks++; if (stray !== 0) begin errors++; $display("FAIL b2b_stray_accepts: got %0d want 0", stray); end
        checks++; if (got_q[0] !== 32'd6 || got_q[1] !== 32'd5 || got_q[2] !== 32'd3) begin
            errors++; $display("FAIL b2b_row1: got %0h %0h %0h want 6 5 3", got_q[0], got_q[1], got_q[2]);
        end
        row[0] = 32'd10; row[1] = 32'd20;
        load_row(2, 7'd2, 1'b0);
        checks++; if (first_acc !== last_hs + 1) begin errors++; $display("FAIL b2b_restart: first accept cycle %0d want %0d", first_acc, last_hs + 1); end
        drain_row(2, 1'b0);
        checks++; if (got_q[0] !== 32'd30 || got_q[1] !== 32'd20 || got_last_q[1] !== 1'b1) begin
            errors++; $display("FAIL b2b_row2: got %0h %0h last=%0b want 1e 14 last=1", got_q[0], got_q[1], got_last_q[1]);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.cfg_len   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic(1'b0);
        test_basic(1'b1);
        test_wrap();
        test_len_one();
        test_len_zero();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
